// File: rtl/lane_framer.sv
// lane_framer: turns data-controller ordered-set tags and payload words into per-byte
// 8b/10b pre-encode symbols with K flags. It tracks frame state, emits LFSR-driven idles
// and inserts clock-compensation (CC) sequences between frames.
// Optional feature macro: LANE_FRAMER_STATS_EN builds the frame/CC counters; without it
// frame_cnt and cc_cnt read as zero.

package lane_framer_pkg;
    typedef enum logic [1:0] {
        OsNone = 2'd0,
        OsScp  = 2'd1,
        OsEcp  = 2'd2,
        OsI    = 2'd3
    } ordered_sets_e;
endpackage

module lane_framer
    import lane_framer_pkg::*;
#(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned CC_PERIOD = 5000,
    parameter int unsigned CC_LEN    = 6
) (
    input  logic                clk_data,
    input  logic                rst_n,
    input  ordered_sets_e       ordered_sets,
    input  logic [DATA_W-1:0]   data_in,
    output logic [DATA_W-1:0]   tx_data,
    output logic [DATA_W/8-1:0] tx_charisk,
    output logic                in_frame,
    output logic                cc_active,
    output logic                cc_pending,
    output logic                err_protocol,
    output logic [15:0]         frame_cnt,
    output logic [15:0]         cc_cnt
);

    localparam int unsigned NumPairs = DATA_W / 16;
    localparam int unsigned TimerW   = $clog2(CC_PERIOD);
    localparam int unsigned RemW     = $clog2(CC_LEN + 1);

    localparam logic [TimerW-1:0] TimerDue  = TimerW'(CC_PERIOD - 1);
    localparam logic [RemW-1:0]   CcRemInit = RemW'(CC_LEN - 1);

    // StCc means a CC sequence has started and more CC cycles remain to be emitted.
    typedef enum logic [1:0] {
        StIdle,
        StFrame,
        StCc
    } state_e;

    typedef enum logic [2:0] {
        SymIdle,
        SymData,
        SymScp,
        SymEcp,
        SymCc
    } sym_e;

    state_e              state_q, state_d;
    logic [RemW-1:0]     cc_rem_q, cc_rem_d;
    logic [TimerW-1:0]   timer_q, timer_d;
    logic [6:0]          lfsr_q, lfsr_d;
    logic [DATA_W-1:0]   tx_data_q, tx_data_d;
    logic [DATA_W/8-1:0] tx_charisk_q, tx_charisk_d;
    logic                cc_active_q;
    logic                cc_pending_q, cc_pending_d;
    logic                err_q, err_d;
    logic                cc_due;
    logic                cc_start;
    sym_e                sym;

    assign cc_due = (timer_q == TimerDue);

    // Per-cycle symbol selection in priority order, plus frame/CC state transitions.
    always_comb begin
        state_d  = state_q;
        cc_rem_d = cc_rem_q;
        sym      = SymIdle;
        err_d    = 1'b0;
        cc_start = 1'b0;
        if (ordered_sets == OsScp) begin
            // SCP always wins; it restarts an open frame and aborts a running CC.
            sym      = SymScp;
            err_d    = (state_q == StFrame);
            state_d  = StFrame;
            cc_rem_d = '0;
        end else if (state_q == StCc) begin
            // A frame cannot be open here, so any ECP is a protocol error and is dropped.
            sym      = SymCc;
            err_d    = (ordered_sets == OsEcp);
            cc_rem_d = cc_rem_q - RemW'(1);
            if (cc_rem_q == RemW'(1)) begin
                state_d = StIdle;
            end
        end else if (ordered_sets == OsEcp) begin
            if (state_q == StFrame) begin
                sym     = SymEcp;
                state_d = StIdle;
            end else begin
                sym   = SymIdle;
                err_d = 1'b1;
            end
        end else if (cc_due && (state_q != StFrame)) begin
            sym      = SymCc;
            cc_start = 1'b1;
            cc_rem_d = CcRemInit;
            state_d  = (CC_LEN > 1) ? StCc : StIdle;
        end else if ((state_q == StFrame) && (ordered_sets == OsNone)) begin
            sym = SymData;
        end else begin
            sym = SymIdle;
        end
    end

    // Timer, deferred-CC flag and idle LFSR next state.
    always_comb begin
        timer_d = timer_q;
        if (cc_start) begin
            timer_d = '0;
        end else if (!cc_due) begin
            timer_d = timer_q + TimerW'(1);
        end
        // Stays set through the ECP cycle so it is held until the CC actually starts.
        cc_pending_d = cc_due && !cc_start && ((state_q == StFrame) || (state_d == StFrame));
        lfsr_d = lfsr_q;
        if (sym == SymIdle) begin
            lfsr_d = {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};
        end
    end

    // Symbol byte pair encoding, replicated across every 16-bit half.
    always_comb begin
        tx_data_d    = '0;
        tx_charisk_d = '1;
        for (int unsigned p = 0; p < NumPairs; p++) begin
            unique case (sym)
                SymScp:  tx_data_d[16*p +: 16] = 16'h5CFB;
                SymEcp:  tx_data_d[16*p +: 16] = 16'hFDFE;
                SymCc:   tx_data_d[16*p +: 16] = 16'hF7F7;
                SymData: tx_data_d[16*p +: 16] = data_in[16*p +: 16];
                default: tx_data_d[16*p +: 16] = {(lfsr_q[0] ? 8'h7C : 8'h1C), 8'hBC};
            endcase
        end
        if (sym == SymData) begin
            tx_charisk_d = '0;
        end
    end

    // Control state registers.
    always_ff @(posedge clk_data or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            cc_rem_q     <= '0;
            timer_q      <= '0;
            lfsr_q       <= 7'h7F;
            cc_pending_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cc_rem_q     <= cc_rem_d;
            timer_q      <= timer_d;
            lfsr_q       <= lfsr_d;
            cc_pending_q <= cc_pending_d;
            err_q        <= err_d;
        end
    end

    // Registered symbol outputs.
    always_ff @(posedge clk_data or negedge rst_n) begin
        if (!rst_n) begin
            tx_data_q    <= '0;
            tx_charisk_q <= '0;
            cc_active_q  <= 1'b0;
        end else begin
            tx_data_q    <= tx_data_d;
            tx_charisk_q <= tx_charisk_d;
            cc_active_q  <= (sym == SymCc);
        end
    end

`ifdef LANE_FRAMER_STATS_EN
    logic [15:0] frame_cnt_q, cc_cnt_q;

    // Completed-frame and CC-start counters, wrapping at 2^16.
    always_ff @(posedge clk_data or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q <= '0;
            cc_cnt_q    <= '0;
        end else begin
            if (sym == SymEcp) begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
            if (cc_start) begin
                cc_cnt_q <= cc_cnt_q + 16'd1;
            end
        end
    end

    assign frame_cnt = frame_cnt_q;
    assign cc_cnt    = cc_cnt_q;
`else
    assign frame_cnt = 16'h0;
    assign cc_cnt    = 16'h0;
`endif

    assign tx_data      = tx_data_q;
    assign tx_charisk   = tx_charisk_q;
    assign in_frame     = (state_q == StFrame);
    assign cc_active    = cc_active_q;
    assign cc_pending   = cc_pending_q;
    assign err_protocol = err_q;

endmodule

// File: tb/tb_lane_framer.sv
// Self-checking bench for lane_framer (DATA_W=16, CC_PERIOD=16, CC_LEN=2) with a
// behavioural reference model and directed plus randomized scenarios.

module tb_lane_framer;
    import lane_framer_pkg::*;

    localparam int DW = 16;
    localparam int CP = 16;
    localparam int CL = 2;

    logic          clk_data = 1'b0;
    logic          rst_n    = 1'b0;
    ordered_sets_e ordered_sets = OsNone;
    logic [DW-1:0] data_in  = '0;
    logic [DW-1:0] tx_data;
    logic [1:0]    tx_charisk;
    logic          in_frame, cc_active, cc_pending, err_protocol;
    logic [15:0]   frame_cnt, cc_cnt;

    lane_framer #(.DATA_W(DW), .CC_PERIOD(CP), .CC_LEN(CL)) dut (
        .clk_data     (clk_data),
        .rst_n        (rst_n),
        .ordered_sets (ordered_sets),
        .data_in      (data_in),
        .tx_data      (tx_data),
        .tx_charisk   (tx_charisk),
        .in_frame     (in_frame),
        .cc_active    (cc_active),
        .cc_pending   (cc_pending),
        .err_protocol (err_protocol),
        .frame_cnt    (frame_cnt),
        .cc_cnt       (cc_cnt)
    );

    always #5 clk_data = ~clk_data;

    int total = 0;
    int bad   = 0;

    // Reference model state.
    bit         m_in_frame;
    int         m_cc_left;   // CC cycles still to emit after the current one
    int         m_since;     // cycles since last CC start, saturating at CP-1
    logic [6:0] m_lfsr;
    int         m_frames, m_ccs;
    logic [15:0] e_data;
    logic [1:0]  e_k;
    bit          e_cc, e_pend, e_err;

    function automatic logic [53:0] exp_vec();
        logic [15:0] ef, ec;
`ifdef LANE_FRAMER_STATS_EN
        ef = m_frames[15:0];
        ec = m_ccs[15:0];
`else
        ef = 16'h0;
        ec = 16'h0;
`endif
        return {e_data, e_k, m_in_frame, e_cc, e_pend, e_err, ef, ec};
    endfunction

    function automatic logic [53:0] act_vec();
        return {tx_data, tx_charisk, in_frame, cc_active, cc_pending, err_protocol,
                frame_cnt, cc_cnt};
    endfunction

    task automatic model_reset();
        m_in_frame = 0; m_cc_left = 0; m_since = 0; m_lfsr = 7'h7F;
        m_frames = 0; m_ccs = 0;
        e_data = '0; e_k = '0; e_cc = 0; e_pend = 0; e_err = 0;
    endtask

    // Drive one input cycle, advance the model, and return #1 after the clock edge.
    task automatic cycle(input ordered_sets_e tag, input logic [15:0] d);
        bit was_in, due, start, idle;
        ordered_sets = tag;
        data_in      = d;
        was_in = m_in_frame;
        due    = (m_since >= CP - 1);
        start  = 0;
        idle   = 0;
        e_err  = 0;
        e_cc   = 0;
        e_k    = 2'b11;
        if (tag == OsScp) begin
            e_data = 16'h5CFB; e_err = m_in_frame; m_in_frame = 1; m_cc_left = 0;
        end else if (m_cc_left > 0) begin
            e_data = 16'hF7F7; e_cc = 1; m_cc_left--; e_err = (tag == OsEcp);
        end else if (tag == OsEcp && m_in_frame) begin
            e_data = 16'hFDFE; m_in_frame = 0; m_frames++;
        end else if (tag == OsEcp) begin
            idle = 1; e_err = 1;
        end else if (due && !m_in_frame) begin
            e_data = 16'hF7F7; e_cc = 1; start = 1; m_ccs++; m_cc_left = CL - 1;
        end else if (m_in_frame && tag == OsNone) begin
            e_data = d; e_k = 2'b00;
        end else begin
            idle = 1;
        end
        if (idle) begin
            e_data = {(m_lfsr[0] ? 8'h7C : 8'h1C), 8'hBC};
            m_lfsr = {m_lfsr[5:0], m_lfsr[6] ^ m_lfsr[5]};
        end
        e_pend  = due && !start && (was_in || m_in_frame);
        m_since = start ? 0 : (due ? m_since : m_since + 1);
        @(posedge clk_data);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        ordered_sets = OsNone;
        data_in = '0;
        model_reset();
        repeat (2) @(posedge clk_data);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        rst_n = 1'b0;
        #1;
        total++;
        if (act_vec() !== 54'h0) begin
            bad++; $display("FAIL reset_state: got %h want 0", act_vec());
        end
        rst_n = 1'b1;
        cycle(OsNone, 16'h0);
        total++;
        if (tx_data !== 16'h7CBC || tx_charisk !== 2'b11 || in_frame !== 1'b0) begin
            bad++; $display("FAIL first_idle: got %h/%b/%b want 7cbc/11/0",
                            tx_data, tx_charisk, in_frame);
        end
        cycle(OsNone, 16'h0);
        total++;
        if (tx_data !== 16'h1CBC || tx_charisk !== 2'b11) begin
            bad++; $display("FAIL second_idle: got %h/%b want 1cbc/11", tx_data, tx_charisk);
        end
        for (int i = 0; i < 6; i++) begin
            cycle(OsI, 16'h0);
            total++;
            if (act_vec() !== exp_vec()) begin
                bad++; $display("FAIL idle_seq %0d: got %h want %h", i, act_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_frame();
        apply_reset();
        cycle(OsScp, 16'h0);
        total++;
        if (tx_data !== 16'h5CFB || tx_charisk !== 2'b11 || in_frame !== 1'b1) begin
            bad++; $display("FAIL frame_scp: got %h/%b/%b want 5cfb/11/1",
                            tx_data, tx_charisk, in_frame);
        end
        cycle(OsNone, 16'hA55A);
        total++;
        if (tx_data[7:0] !== 8'h5A || tx_data[15:8] !== 8'hA5 || tx_charisk !== 2'b00) begin
            bad++; $display("FAIL frame_data0: got %h/%b want a55a/00", tx_data, tx_charisk);
        end
        cycle(OsNone, 16'h1234);
        total++;
        if (tx_data !== 16'h1234 || tx_charisk !== 2'b00) begin
            bad++; $display("FAIL frame_data1: got %h/%b want 1234/00", tx_data, tx_charisk);
        end
        cycle(OsEcp, 16'h0);
        total++;
        if (tx_data !== 16'hFDFE || tx_charisk !== 2'b11 || in_frame !== 1'b0) begin
            bad++; $display("FAIL frame_ecp: got %h/%b/%b want fdfe/11/0",
                            tx_data, tx_charisk, in_frame);
        end
        total++;
        if (act_vec() !== exp_vec()) begin
            bad++; $display("FAIL frame_cnt: got %h want %h", act_vec(), exp_vec());
        end
    endtask

    task automatic test_cc_idle();
        apply_reset();
        for (int c = 1; c <= 40; c++) begin
            cycle(OsNone, 16'h0);
            total++;
            if (act_vec() !== exp_vec()) begin
                bad++; $display("FAIL cc_idle cyc %0d: got %h want %h", c, act_vec(), exp_vec());
            end
            if (c == 15 || c == 18 || c == 31) begin
                total++;
                if (cc_active !== 1'b0) begin
                    bad++; $display("FAIL cc_off cyc %0d: got %b want 0", c, cc_active);
                end
            end
            if (c == 16 || c == 17 || c == 32 || c == 33) begin
                total++;
                if (cc_active !== 1'b1 || tx_data !== 16'hF7F7 || tx_charisk !== 2'b11) begin
                    bad++; $display("FAIL cc_on cyc %0d: got %b/%h/%b want 1/f7f7/11",
                                    c, cc_active, tx_data, tx_charisk);
                end
            end
        end
    endtask

    task automatic test_cc_deferred();
        apply_reset();
        cycle(OsNone, 16'h0);
        cycle(OsScp, 16'h0);
        for (int i = 0; i < 20; i++) begin
            cycle(OsNone, 16'($urandom));
            total++;
            if (act_vec() !== exp_vec()) begin
                bad++; $display("FAIL defer_data %0d: got %h want %h", i, act_vec(), exp_vec());
            end
        end
        total++;
        if (cc_pending !== 1'b1 || cc_active !== 1'b0) begin
            bad++; $display("FAIL defer_pending: got %b/%b want 1/0", cc_pending, cc_active);
        end
        cycle(OsEcp, 16'h0);
        total++;
        if (tx_data !== 16'hFDFE || cc_pending !== 1'b1) begin
            bad++; $display("FAIL defer_ecp: got %h/%b want fdfe/1", tx_data, cc_pending);
        end
        cycle(OsNone, 16'h0);
        total++;
        if (cc_active !== 1'b1 || tx_data !== 16'hF7F7 || cc_pending !== 1'b0) begin
            bad++; $display("FAIL defer_start: got %b/%h/%b want 1/f7f7/0",
                            cc_active, tx_data, cc_pending);
        end
    endtask

    task automatic test_protocol_err();
        apply_reset();
        cycle(OsEcp, 16'h0);
        total++;
        if (tx_data[7:0] !== 8'hBC || err_protocol !== 1'b1 || in_frame !== 1'b0) begin
            bad++; $display("FAIL err_ecp: got %h/%b/%b want xxbc/1/0",
                            tx_data, err_protocol, in_frame);
        end
        cycle(OsNone, 16'h0);
        total++;
        if (err_protocol !== 1'b0) begin
            bad++; $display("FAIL err_pulse: got %b want 0", err_protocol);
        end
        cycle(OsScp, 16'h0);
        cycle(OsScp, 16'h0);
        total++;
        if (tx_data !== 16'h5CFB || err_protocol !== 1'b1 || in_frame !== 1'b1) begin
            bad++; $display("FAIL err_scp: got %h/%b/%b want 5cfb/1/1",
                            tx_data, err_protocol, in_frame);
        end
        cycle(OsNone, 16'hBEEF);
        total++;
        if (act_vec() !== exp_vec()) begin
            bad++; $display("FAIL err_after: got %h want %h", act_vec(), exp_vec());
        end
    endtask

    task automatic test_abort_and_reset();
        bit found;
        apply_reset();
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            cycle(OsNone, 16'h0);
            found = (cc_active === 1'b1);
        end
        total++;
        if (!found) begin
            bad++; $display("FAIL abort_wait: got no cc within 40 cycles want cc");
        end
        cycle(OsScp, 16'h0);
        total++;
        if (tx_data !== 16'h5CFB || cc_active !== 1'b0 || in_frame !== 1'b1) begin
            bad++; $display("FAIL abort_scp: got %h/%b/%b want 5cfb/0/1",
                            tx_data, cc_active, in_frame);
        end
        cycle(OsNone, 16'h7777);
        total++;
        if (act_vec() !== exp_vec()) begin
            bad++; $display("FAIL abort_data: got %h want %h", act_vec(), exp_vec());
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (act_vec() !== 54'h0) begin
            bad++; $display("FAIL async_reset: got %h want 0", act_vec());
        end
        model_reset();
        @(posedge clk_data);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        int r;
        ordered_sets_e tag;
        apply_reset();
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 99);
            tag = (r < 55) ? OsNone : (r < 70) ? OsI : (r < 82) ? OsScp : OsEcp;
            cycle(tag, 16'($urandom));
            total++;
            if (act_vec() !== exp_vec()) begin
                bad++; $display("FAIL random cyc %0d: got %h want %h", i, act_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_cc_idle();
        test_cc_deferred();
        test_protocol_err();
        test_abort_and_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
